strobe_to_stable: RTL and testbench
===================================

// Module: strobe_to_stable
// PURPOSE
//   Inverse of the level-to-strobe edge detector: turns 1-cycle strobes into a stable high level
//   held HOLD_CYCLES clocks, followed by a guaranteed low gap of GAP_CYCLES clocks.
//   Strobes arriving while busy are queued in a saturating pending counter and replayed in order.
//   Used to drive LEDs, slow peripherals and test pins from single-cycle core events.
// PARAMETERS
//   HOLD_CYCLES  4  clocks q stays high per accepted strobe; must be >= 1
//   GAP_CYCLES   2  minimum clocks q stays low between two high periods; must be >= 1
//   PEND_W       2  width of pending-strobe counter; saturates at 2**PEND_W-1
// PORTS
//   clk       in   1       system clock, all logic on posedge
//   rst       in   1       asynchronous, active-low reset
//   strobe    in   1       single-cycle event; each high cycle counts as one event
//   clr_ovr   in   1       synchronous clear of sticky overrun
//   q         out  1       stretched stable level (registered)
//   busy      out  1       high whenever state != IDLE
//   pending   out  PEND_W  queued strobes not yet replayed
//   overrun   out  1       sticky; set when a strobe is dropped at pending saturation
// BEHAVIOUR
//   - Reset (rst low, async): state=IDLE, q=0, busy=0, pending=0, overrun=0, cnt=0.
//   - States IDLE, HOLD, GAP; down-counter cnt, width $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1).
//   - IDLE: strobe=1 -> HOLD, cnt=HOLD_CYCLES-1. q rises the cycle after the strobe edge (latency 1).
//   - HOLD: q=1. cnt!=0 -> decrement. cnt==0 -> GAP, cnt=GAP_CYCLES-1.
//     q is high for exactly HOLD_CYCLES clocks.
//   - GAP: q=0. cnt!=0 -> decrement. cnt==0: if (pending!=0 || strobe) -> HOLD, cnt=HOLD_CYCLES-1;
//     else -> IDLE.
//   - Pending update each cycle: next = pending + (strobe accepted into queue) - (replay consumed).
//     - A strobe counts into the queue in HOLD and GAP.
//     - A replay is consumed on the GAP->HOLD transition.
//     - A strobe and a replay in the same cycle leave pending unchanged.
//   - Saturation: strobe with pending==2**PEND_W-1 and no replay in that cycle is dropped;
//     overrun<=1. overrun holds until clr_ovr.
//   - clr_ovr and a new drop in the same cycle: overrun stays 1 (set wins).
//   - q, busy and overrun are registered; no combinational path from strobe to any output.
//   - rst asserted mid-HOLD or mid-GAP: immediate return to reset values; queued strobes are lost.
// CONFIGURATION
//   - STROBE_RETRIGGER_EN defined:
//     - A strobe in HOLD reloads cnt=HOLD_CYCLES-1 instead of queuing, extending the high
//       period. It is not counted in pending.
//     - Strobes in GAP still queue normally.
//   - STROBE_RETRIGGER_EN undefined: every strobe in HOLD queues as described in BEHAVIOUR.
// STRUCTURE
//   - Package stable_strobe_pkg: state encoding localparams (ST_IDLE=2'd0, ST_HOLD=2'd1,
//     ST_GAP=2'd2) and the clog2-based counter-width function, shared with the edge detector's bench.
//   - One sub-module: strobe_sat_counter (PEND_W-bit up/down saturating counter, inc/dec/full/ovf).
//     The FSM and hold/gap counter stay in the top module.
// TESTING
//   1. Reset then one strobe at cycle 10, defaults -> q=1 cycles 11..14, q=0 at 15; busy low from 17.
//   2. Strobes at cycles 10 and 12 -> pending=1 at 13; second high period cycles 17..20; pending=0 at 17.
//   3. Five strobes in cycles 10..14, PEND_W=2 -> pending saturates at 3, one dropped, overrun=1;
//      four high periods total.
//   4. Strobe in the last GAP cycle with pending=0 -> direct GAP->HOLD, no IDLE cycle, pending stays 0.
//   5. rst low at cycle 12 during HOLD with pending=2 -> q, busy, pending, overrun all 0 the same cycle.
//   6. STROBE_RETRIGGER_EN, strobes at cycles 10 and 13 -> q high cycles 11..17 continuously, pending=0.

Source files
------------

// File: rtl/stable_strobe_pkg.sv
// Shared definitions for the strobe stretcher: state encoding and hold/gap counter sizing.
package stable_strobe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Width of a down-counter that can hold the larger of the two period lengths.
  function automatic int unsigned cnt_width(input int unsigned hold_cycles,
                                            input int unsigned gap_cycles);
    int unsigned m;
    m = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/strobe_sat_counter.sv
// Saturating up/down counter of queued strobes; ovf pulses when an increment is lost at full.
module strobe_sat_counter #(
  parameter int unsigned PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] count,
  output logic              ovf
);

  logic [PEND_W-1:0] count_q, count_d;
  logic              full;

  always_comb begin
    full    = (count_q == '1);
    ovf     = inc & ~dec & full;
    count_d = count_q;
    if (inc && !dec && !full) begin
      count_d = count_q + 1'b1;
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/strobe_to_stable.sv
// Stretches single-cycle strobes into HOLD_CYCLES-high / GAP_CYCLES-low pulses with a replay queue.
// Optional STROBE_RETRIGGER_EN: a strobe during the high period extends it instead of queuing.
module strobe_to_stable #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned PEND_W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              strobe,
  input  logic              clr_ovr,
  output logic              q,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overrun
);

  import stable_strobe_pkg::*;

  localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              q_q, q_d;
  logic              busy_q, busy_d;
  logic              ovr_q, ovr_d;
  logic              pend_inc, pend_dec, pend_ovf;
  logic [PEND_W-1:0] pend_cnt;

  strobe_sat_counter #(
    .PEND_W(PEND_W)
  ) u_pend (
    .clk  (clk),
    .rst  (rst),
    .inc  (pend_inc),
    .dec  (pend_dec),
    .count(pend_cnt),
    .ovf  (pend_ovf)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_inc = 1'b0;
    pend_dec = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (strobe) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      ST_HOLD: begin
`ifdef STROBE_RETRIGGER_EN
        if (strobe) begin
          cnt_d = HOLD_LD;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = ST_GAP;
          cnt_d   = GAP_LD;
        end
`else
        pend_inc = strobe;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = ST_GAP;
          cnt_d   = GAP_LD;
        end
`endif
      end
      ST_GAP: begin
        pend_inc = strobe;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if ((pend_cnt != '0) || strobe) begin
          // A strobe landing on the restart cycle counts in and out at once, so pending holds.
          state_d  = ST_HOLD;
          cnt_d    = HOLD_LD;
          pend_dec = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    q_d    = (state_d == ST_HOLD);
    busy_d = (state_d != ST_IDLE);
    ovr_d  = pend_ovf | (ovr_q & ~clr_ovr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign q       = q_q;
  assign busy    = busy_q;
  assign pending = pend_cnt;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_strobe_to_stable.sv
// Randomized bench for strobe_to_stable against a timestamp-based reference of the high/gap windows.
module tb_strobe_to_stable;

  localparam int HOLD = 4;
  localparam int GAP  = 2;
  localparam int PW   = 2;
  localparam int PMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          strobe;
  logic          clr_ovr;
  logic          q;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overrun;

  int errors = 0;
  int checks = 0;

  // Reference: each high period is a window [hi_start, hi_end); busy until gap_end.
  int cyc;
  int hi_start, hi_end, gap_end;
  int m_pend;
  int m_ovr;

  always #5 clk = ~clk;

  strobe_to_stable #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP),
    .PEND_W     (PW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .strobe (strobe),
    .clr_ovr(clr_ovr),
    .q      (q),
    .busy   (busy),
    .pending(pending),
    .overrun(overrun)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    hi_start = 0;
    hi_end   = 0;
    gap_end  = 0;
    m_pend   = 0;
    m_ovr    = 0;
  endtask

  task automatic model_step(input bit s, input bit clr);
    bit drop;
    drop = 1'b0;
    if (cyc >= gap_end - 1 && (m_pend > 0 || s)) begin
      if (cyc == gap_end - 1 && !s) m_pend--;
      hi_start = cyc + 1;
      hi_end   = hi_start + HOLD;
      gap_end  = hi_end + GAP;
    end else if (s) begin
`ifdef STROBE_RETRIGGER_EN
      if (cyc >= hi_start && cyc < hi_end) begin
        hi_end  = cyc + 1 + HOLD;
        gap_end = hi_end + GAP;
      end else
`endif
      if (m_pend == PMAX) drop = 1'b1;
      else m_pend++;
    end
    if (drop) m_ovr = 1;
    else if (clr) m_ovr = 0;
  endtask

  task automatic run_cycle(input bit s, input bit clr);
    @(posedge clk);
    #1;
    cyc++;
    check_val("q", q, (cyc >= hi_start && cyc < hi_end) ? 1 : 0);
    check_val("busy", busy, (cyc < gap_end) ? 1 : 0);
    check_val("pending", pending, m_pend);
    check_val("overrun", overrun, m_ovr);
    strobe  = s;
    clr_ovr = clr;
    model_step(s, clr);
  endtask

  task automatic do_reset();
    #1;
    rst     = 1'b0;
    strobe  = 1'b0;
    clr_ovr = 1'b0;
    #1;
    check_val("rst_q", q, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_pending", pending, 0);
    check_val("rst_overrun", overrun, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    rst     = 1'b0;
    strobe  = 1'b0;
    clr_ovr = 1'b0;
    cyc     = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("init_q", q, 0);
    check_val("init_busy", busy, 0);
    check_val("init_pending", pending, 0);
    check_val("init_overrun", overrun, 0);
    rst = 1'b1;

    // Single strobe, then two strobes with one queued.
    repeat (9) run_cycle(1'b0, 1'b0);
    run_cycle(1'b1, 1'b0);
    repeat (10) run_cycle(1'b0, 1'b0);
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b0, 1'b0);
    run_cycle(1'b1, 1'b0);
    repeat (14) run_cycle(1'b0, 1'b0);

    // Burst of five: queue saturates and one strobe is dropped.
    repeat (5) run_cycle(1'b1, 1'b0);
    repeat (30) run_cycle(1'b0, 1'b0);
    check_val("burst_overrun", overrun, 1);
    run_cycle(1'b0, 1'b1);
    repeat (3) run_cycle(1'b0, 1'b0);

    // Strobe on the final gap cycle restarts the high period directly.
    run_cycle(1'b1, 1'b0);
    repeat (5) run_cycle(1'b0, 1'b0);
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b0, 1'b0);
    check_val("restart_q", q, 1);
    check_val("restart_pending", pending, 0);
    repeat (12) run_cycle(1'b0, 1'b0);

    // Reset during the high period with two strobes queued.
    repeat (3) run_cycle(1'b1, 1'b0);
    run_cycle(1'b0, 1'b0);
    do_reset();
    repeat (4) run_cycle(1'b0, 1'b0);

    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 3000; i++) begin
      run_cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 149) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
